hex_number_entry: RTL and testbench



---
 rtl/hex_entry_pkg.sv | 12 +
 rtl/key_edge_sync.sv | 37 +++
 rtl/hex_number_entry.sv | 102 ++++++++++
 tb/tb_hex_number_entry.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex number entry block.
package hex_entry_pkg;

    typedef enum logic {
        ENTRY,
        HOLD
    } entry_state_t;

    localparam int DEFAULT_NUM_DIGITS = 8;
    localparam int NIBBLE_W           = 4;

endpackage

// File: rtl/key_edge_sync.sv
// Raw active-low pushbutton -> 2-FF synchronizer -> registered one-cycle press pulse.
module key_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse
);

    logic       sync_meta;
    logic       sync_key;
    logic       key_prev;
    logic [1:0] flushed;
    logic       armed;

    // NOTE: reset is synchronous here, so rst_n appears only inside the clocked block
    // and every state update uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
            key_prev  <= 1'b1;
            flushed   <= 2'b00;
            armed     <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_meta <= key_n;
            sync_key  <= sync_meta;
            key_prev  <= sync_key;
            flushed   <= {flushed[0], 1'b1};
            // Arm only once a real released level has crossed both stages, so a key
            // held down through reset never looks like a fresh press.
            armed     <= armed | (flushed[1] & sync_key);
            pulse     <= armed & key_prev & ~sync_key;
        end
    end

endmodule

// File: rtl/hex_number_entry.sv
// Multi-digit hex keypad entry: assembles nibbles into a number and hands the committed
// value downstream on a valid/ready handshake.
module hex_number_entry
    import hex_entry_pkg::*;
#(
    parameter  int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    localparam int DATA_W     = NIBBLE_W * NUM_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          digit_in,
    input  logic                key_enter_n,
    input  logic                key_back_n,
    input  logic                key_commit_n,
    output logic [DATA_W-1:0]   entry_value,
    output logic [3:0]          digit_count,
    output logic                overflow,
    output logic [DATA_W-1:0]   number_out,
    output logic                number_valid,
    input  logic                number_ready
);

    logic [NIBBLE_W-1:0] digit_meta;
    logic [NIBBLE_W-1:0] digit_sync;
    logic                enter_pulse;
    logic                back_pulse;
    logic                commit_pulse;
    entry_state_t        state;

    // The switches share the key pipeline depth so the nibble is settled when the pulse fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_meta <= '0;
            digit_sync <= '0;
        end else begin
            digit_meta <= digit_in;
            digit_sync <= digit_meta;
        end
    end

    key_edge_sync u_enter_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .pulse (enter_pulse)
    );

    key_edge_sync u_back_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_back_n),
        .pulse (back_pulse)
    );

    key_edge_sync u_commit_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_commit_n),
        .pulse (commit_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_value  <= '0;
            digit_count  <= '0;
            overflow     <= 1'b0;
            number_out   <= '0;
            number_valid <= 1'b0;
            state        <= ENTRY;
        end else begin
            // Commit wins the cycle even in HOLD, where it is simply discarded.
            if (commit_pulse) begin
                if (state == ENTRY) begin
                    number_out   <= entry_value;
                    number_valid <= 1'b1;
                    entry_value  <= '0;
                    digit_count  <= '0;
                    overflow     <= 1'b0;
                    state        <= HOLD;
                end
            end else if (back_pulse) begin
                if (digit_count != 4'd0) begin
                    entry_value <= entry_value >> NIBBLE_W;
                    digit_count <= digit_count - 4'd1;
                end
            end else if (enter_pulse) begin
                if (digit_count < 4'(NUM_DIGITS)) begin
                    entry_value <= (entry_value << NIBBLE_W) | DATA_W'(digit_sync);
                    digit_count <= digit_count + 4'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (state == HOLD && number_ready) begin
                number_valid <= 1'b0;
                state        <= ENTRY;
            end
        end
    end

endmodule

// File: tb/tb_hex_number_entry.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hex_number_entry;

    typedef struct packed {
        logic [31:0] entry;
        logic [3:0]  count;
        logic        ovf;
    } exp_t;

    localparam logic [2:0] K_ENTER  = 3'b001;
    localparam logic [2:0] K_BACK   = 3'b010;
    localparam logic [2:0] K_COMMIT = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit_in = 4'h0;
    logic        key_enter_n = 1'b1;
    logic        key_back_n = 1'b1;
    logic        key_commit_n = 1'b1;
    logic [31:0] entry_value;
    logic [3:0]  digit_count;
    logic        overflow;
    logic [31:0] number_out;
    logic        number_valid;
    logic        number_ready = 1'b0;

    exp_t        eq[$];
    logic [31:0] nq[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    logic [31:0] prev_e = '0;
    logic [3:0]  prev_c = '0;
    logic        prev_o = 1'b0;
    exp_t        got;
    logic [31:0] want_n;

    always #5 clk = ~clk;

    hex_number_entry dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_in     (digit_in),
        .key_enter_n  (key_enter_n),
        .key_back_n   (key_back_n),
        .key_commit_n (key_commit_n),
        .entry_value  (entry_value),
        .digit_count  (digit_count),
        .overflow     (overflow),
        .number_out   (number_out),
        .number_valid (number_valid),
        .number_ready (number_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_keys(input logic [2:0] mask);
        key_enter_n  = ~mask[0];
        key_back_n   = ~mask[1];
        key_commit_n = ~mask[2];
    endtask

    // One press: nibble settles first, keys held 5 cycles, then a release gap.
    task automatic press(input logic [2:0] mask, input logic [3:0] d, input bit chg,
                         input logic [31:0] e, input logic [3:0] c, input bit o,
                         input bit lat = 1'b0, input logic [3:0] c_old = 4'd0);
        digit_in = d;
        tick(2);
        if (chg) eq.push_back(exp_t'{entry: e, count: c, ovf: o});
        set_keys(mask);
        if (lat) begin
            tick(3);
            check("latency_edge_n2", 32'(digit_count), 32'(c_old));
            tick(1);
            check("latency_edge_n3", 32'(digit_count), 32'(c));
            tick(1);
        end else begin
            tick(5);
        end
        set_keys(3'b000);
        tick(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
    endtask

    // Monitor: any change of the live-entry outputs must match the next expected update,
    // and every handshake must deliver the next expected committed number.
    always @(negedge clk) begin
        if (mon_en) begin
            if ({entry_value, digit_count, overflow} != {prev_e, prev_c, prev_o}) begin
                if (eq.size() == 0) begin
                    check("unexpected_entry_update", entry_value, prev_e);
                end else begin
                    got = eq.pop_front();
                    check("entry_value", entry_value, got.entry);
                    check("digit_count", 32'(digit_count), 32'(got.count));
                    check("overflow", 32'(overflow), 32'(got.ovf));
                end
                prev_e = entry_value;
                prev_c = digit_count;
                prev_o = overflow;
            end
            if (number_valid && number_ready) begin
                if (nq.size() == 0) begin
                    check("unexpected_handshake", 32'(number_valid), 32'd0);
                end else begin
                    want_n = nq.pop_front();
                    check("number_out", number_out, want_n);
                end
            end
        end
    end

    logic [31:0] t2_entry [8] = '{32'hA, 32'hAB, 32'hABC, 32'hABCD,
                                  32'hABCDE, 32'hABCDEF, 32'hABCDEF0, 32'hABCDEF01};
    logic [3:0]  t2_digit [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

    initial begin
        int waited;

        // Reset state
        set_keys(3'b000);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("reset_entry_value", entry_value, 32'h0);
        check("reset_digit_count", 32'(digit_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_number_out", number_out, 32'h0);
        check("reset_number_valid", 32'(number_valid), 32'd0);
        mon_en = 1'b1;

        // Three digits with exact pipeline latency
        press(K_ENTER, 4'h1, 1'b1, 32'h1,   4'd1, 1'b0, 1'b1, 4'd0);
        press(K_ENTER, 4'h2, 1'b1, 32'h12,  4'd2, 1'b0, 1'b1, 4'd1);
        press(K_ENTER, 4'h3, 1'b1, 32'h123, 4'd3, 1'b0, 1'b1, 4'd2);

        // Fill all eight digits, overflow on the ninth, backspace keeps overflow
        eq.push_back(exp_t'{entry: 32'h0, count: 4'd0, ovf: 1'b0});
        do_reset();
        for (int i = 0; i < 8; i++)
            press(K_ENTER, t2_digit[i], 1'b1, t2_entry[i], 4'(i + 1), 1'b0);
        press(K_ENTER, 4'h7, 1'b1, 32'hABCDEF01, 4'd8, 1'b1);
        check("overflow_sticky_set", 32'(overflow), 32'd1);
        press(K_BACK, 4'h0, 1'b1, 32'h0ABCDEF0, 4'd7, 1'b1);

        // Commit with ready already high clears overflow and delivers immediately
        number_ready = 1'b1;
        nq.push_back(32'h0ABCDEF0);
        press(K_COMMIT, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0);
        check("valid_after_quick_handshake", 32'(number_valid), 32'd0);
        number_ready = 1'b0;

        // Commit 0x123 against a stalled consumer
        press(K_ENTER, 4'h1, 1'b1, 32'h1,   4'd1, 1'b0);
        press(K_ENTER, 4'h2, 1'b1, 32'h12,  4'd2, 1'b0);
        press(K_ENTER, 4'h3, 1'b1, 32'h123, 4'd3, 1'b0);
        nq.push_back(32'h123);
        press(K_COMMIT, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid_stable", 32'(number_valid), 32'd1);
            check("hold_number_stable", number_out, 32'h123);
            tick(1);
        end
        check("entry_cleared_on_commit", entry_value, 32'h0);

        // Editing continues in HOLD; commit is dropped there
        press(K_ENTER, 4'h5, 1'b1, 32'h5, 4'd1, 1'b0);
        press(K_COMMIT, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0);
        check("hold_commit_dropped_number", number_out, 32'h123);
        check("hold_commit_dropped_valid", 32'(number_valid), 32'd1);
        number_ready = 1'b1;
        tick(1);
        number_ready = 1'b0;
        check("valid_drops_after_ready", 32'(number_valid), 32'd0);
        nq.push_back(32'h5);
        press(K_COMMIT, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0);
        check("second_commit_valid", 32'(number_valid), 32'd1);
        check("second_commit_number", number_out, 32'h5);
        number_ready = 1'b1;
        tick(1);
        number_ready = 1'b0;

        // Back beats enter in the same cycle; empty commit delivers zero
        press(K_ENTER, 4'h1, 1'b1, 32'h1,  4'd1, 1'b0);
        press(K_ENTER, 4'h2, 1'b1, 32'h12, 4'd2, 1'b0);
        press(K_BACK | K_ENTER, 4'h9, 1'b1, 32'h1, 4'd1, 1'b0);
        press(K_BACK, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0);
        press(K_BACK, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0);
        nq.push_back(32'h0);
        press(K_COMMIT, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0);
        check("empty_commit_valid", 32'(number_valid), 32'd1);
        check("empty_commit_number", number_out, 32'h0);
        number_ready = 1'b1;
        tick(1);
        number_ready = 1'b0;

        // Reset in HOLD with a partial entry and all keys held through reset
        press(K_ENTER, 4'h1, 1'b1, 32'h1, 4'd1, 1'b0);
        press(K_COMMIT, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0);
        press(K_ENTER, 4'h3, 1'b1, 32'h3, 4'd1, 1'b0);
        check("pending_before_reset", number_out, 32'h1);
        eq.push_back(exp_t'{entry: 32'h0, count: 4'd0, ovf: 1'b0});
        set_keys(K_ENTER | K_BACK | K_COMMIT);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("midreset_number_out", number_out, 32'h0);
        check("midreset_number_valid", 32'(number_valid), 32'd0);
        check("midreset_digit_count", 32'(digit_count), 32'd0);
        tick(10);
        check("held_keys_no_pulse_count", 32'(digit_count), 32'd0);
        check("held_keys_no_pulse_valid", 32'(number_valid), 32'd0);
        set_keys(3'b000);
        tick(6);
        press(K_ENTER, 4'h7, 1'b1, 32'h7, 4'd1, 1'b0);

        waited = 0;
        while ((eq.size() != 0 || nq.size() != 0) && waited < 50) begin
            tick(1);
            waited++;
        end
        check("scoreboard_drained", 32'(eq.size() + nq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
